// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types and helpers for the 4x4 keypad scanner
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    typedef logic [NUM_KEYS-1:0] key_vec_t;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2,
        COL3 = 2'd3
    } col_state_t;

    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        return {col, row};
    endfunction

    // Active-low one-cold drive pattern for a column state
    function automatic logic [NUM_COLS-1:0] col_drive(input col_state_t s);
        return ~(NUM_COLS'(1) << s);
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix pins and committed key outputs
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row_in;
    logic [NUM_COLS-1:0] col_out;
    key_vec_t            onehot;
    logic                key_valid;
    logic                key_pulse;

    modport master (
        input  row_in,
        output col_out,
        output onehot,
        output key_valid,
        output key_pulse
    );

    modport slave (
        output row_in,
        input  col_out,
        input  onehot,
        input  key_valid,
        input  key_pulse
    );

endinterface

// File: rtl/keypad_debounce.sv
// rtl/keypad_debounce.sv - scan-level debounce and one-hot commit of keypad snapshots
// Optional auto-repeat pulses when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    input  key_vec_t snap_i,
    input  logic     scan_done_i,
    output key_vec_t onehot_o,
    output logic     key_valid_o,
    output logic     key_pulse_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    if (DEBOUNCE_SCANS < 1) begin : g_bad_debounce
        $error("DEBOUNCE_SCANS must be at least 1");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("REPEAT_SCANS must be at least 1");
    end

    key_vec_t         prev_snap_q;
    key_vec_t         onehot_q;
    logic [CNT_W-1:0] stable_cnt_q;
    logic             key_valid_q;
    logic             key_pulse_q;

    logic same;
    logic saturated;
    logic commit;
    logic is_zero;
    logic is_single;
    logic rep_fire;

    assign same      = (snap_i == prev_snap_q);
    assign saturated = (stable_cnt_q == CNT_W'(DEBOUNCE_SCANS));
    // Commit only on the step that reaches saturation: once per stable pattern
    assign commit    = scan_done_i && same && (stable_cnt_q == CNT_W'(DEBOUNCE_SCANS - 1));
    assign is_zero   = (snap_i == '0);
    assign is_single = !is_zero && ((snap_i & (snap_i - key_vec_t'(1))) == '0);

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);

    logic [REP_W-1:0] rep_cnt_q;
    logic             rep_tick;

    assign rep_tick = scan_done_i && same && saturated && key_valid_q && (prev_snap_q == onehot_q);
    assign rep_fire = rep_tick && (rep_cnt_q == REP_W'(REPEAT_SCANS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q <= '0;
        end else if (scan_done_i && (!same || commit || !key_valid_q)) begin
            rep_cnt_q <= '0;
        end else if (rep_fire) begin
            rep_cnt_q <= '0;
        end else if (rep_tick) begin
            rep_cnt_q <= rep_cnt_q + REP_W'(1);
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_snap_q  <= '0;
            onehot_q     <= '0;
            stable_cnt_q <= '0;
            key_valid_q  <= 1'b0;
            key_pulse_q  <= 1'b0;
        end else begin
            key_pulse_q <= rep_fire;
            if (scan_done_i) begin
                if (!same) begin
                    prev_snap_q  <= snap_i;
                    stable_cnt_q <= '0;
                end else if (!saturated) begin
                    stable_cnt_q <= stable_cnt_q + CNT_W'(1);
                end
                // Two or more keys (ghosting / multi-press) keep the previous commit
                if (commit) begin
                    if (is_single) begin
                        onehot_q    <= snap_i;
                        key_valid_q <= 1'b1;
                        key_pulse_q <= (snap_i != onehot_q) || !key_valid_q;
                    end else if (is_zero) begin
                        onehot_q    <= '0;
                        key_valid_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign onehot_o    = onehot_q;
    assign key_valid_o = key_valid_q;
    assign key_pulse_o = key_pulse_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad column scanner with debounced one-hot output
// Auto-repeat pulses are built only when KEYPAD_REPEAT_EN is defined.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_SCANS   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    keypad_scanner_if.master kp
);

    localparam int DIV_W = $clog2(SCAN_DIV);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be at least 4");
    end

    logic [NUM_ROWS-1:0] sync1_q;
    logic [NUM_ROWS-1:0] sync2_q;
    logic [DIV_W-1:0]    div_cnt_q;
    col_state_t          col_q;
    col_state_t          col_next;
    logic [NUM_COLS-1:0] col_out_q;
    key_vec_t            snap_q;
    key_vec_t            snap_d;
    logic                scan_done_q;
    logic                col_end;

    assign col_end  = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    assign col_next = col_state_t'(col_q + 2'd1);

    // Rows are active-low, so a pressed key reads as a set snapshot bit
    always_comb begin
        snap_d = snap_q;
        for (int r = 0; r < NUM_ROWS; r++) begin
            snap_d[key_index(2'(r), col_q)] = ~sync2_q[r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            div_cnt_q   <= '0;
            col_q       <= COL0;
            col_out_q   <= col_drive(COL0);
            snap_q      <= '0;
            scan_done_q <= 1'b0;
        end else begin
            sync1_q     <= kp.row_in;
            sync2_q     <= sync1_q;
            scan_done_q <= col_end && (col_q == COL3);
            if (col_end) begin
                div_cnt_q <= '0;
                col_q     <= col_next;
                col_out_q <= col_drive(col_next);
                snap_q    <= snap_d;
            end else begin
                div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
        end
    end

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS),
        .REPEAT_SCANS  (REPEAT_SCANS)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .snap_i     (snap_q),
        .scan_done_i(scan_done_q),
        .onehot_o   (kp.onehot),
        .key_valid_o(kp.key_valid),
        .key_pulse_o(kp.key_pulse)
    );

    assign kp.col_out = col_out_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - randomized self-checking bench for keypad_scanner against a scan-level model
module tb_keypad_scanner;
    import keypad_pkg::*;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 4;
    localparam int SCAN_CYC = 4 * SCAN_DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_scanner_if kif ();

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .kp   (kif)
    );

    // Diode-free matrix: a row is pulled low by any pressed key in a driven column
    logic [15:0] pressed = '0;
    always_comb begin
        kif.row_in = '1;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (pressed[4*c+r] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int scan_no  = 0;

    // Scan-level model: run length of identical snapshots decides commits
    int          run_len;
    logic [15:0] m_last, m_onehot, vis_onehot;
    logic        m_valid, m_pulse, vis_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        run_len    = 1;
        m_last     = '0;
        m_onehot   = '0;
        m_valid    = 1'b0;
        m_pulse    = 1'b0;
        vis_onehot = '0;
        vis_valid  = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] snap);
        m_pulse = 1'b0;
        if (snap == m_last) run_len++;
        else begin
            m_last  = snap;
            run_len = 1;
        end
        if (run_len == DEB + 1) begin
            if ($countones(snap) == 1) begin
                m_pulse  = (snap != m_onehot) || !m_valid;
                m_onehot = snap;
                m_valid  = 1'b1;
            end else if (snap == 16'h0000) begin
                m_onehot = '0;
                m_valid  = 1'b0;
            end
        end
`ifdef KEYPAD_REPEAT_EN
        else if (run_len > DEB + 1 && m_valid && m_onehot == snap && ((run_len - DEB - 1) % REP) == 0)
            m_pulse = 1'b1;
`endif
    endtask

    task automatic run_scan(input logic [15:0] keys, input int ncyc);
        logic [3:0] exp_col;
        pressed = keys;
        for (int i = 0; i < ncyc; i++) begin
            if (i == 1) begin
                vis_onehot = m_onehot;
                vis_valid  = m_valid;
            end
            exp_col = ~(4'b0001 << (i / SCAN_DIV));
            check($sformatf("scan%0d c%0d col_out", scan_no, i), kif.col_out, exp_col);
            check($sformatf("scan%0d c%0d onehot", scan_no, i), kif.onehot, vis_onehot);
            check($sformatf("scan%0d c%0d key_valid", scan_no, i), kif.key_valid, vis_valid);
            check($sformatf("scan%0d c%0d key_pulse", scan_no, i), kif.key_pulse,
                  (i == 1) ? m_pulse : 1'b0);
            @(negedge clk);
        end
        if (ncyc == SCAN_CYC) model_scan(keys);
        scan_no++;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " col_out"}, kif.col_out, 4'b1110);
        check({tag, " onehot"}, kif.onehot, 16'h0000);
        check({tag, " key_valid"}, kif.key_valid, 1'b0);
        check({tag, " key_pulse"}, kif.key_pulse, 1'b0);
    endtask

    initial begin
        logic [15:0] pat;
        int          a, b, kind, hold;

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) run_scan(16'h0000, SCAN_CYC);
        for (int k = 0; k < 11; k++) run_scan(16'h0008, SCAN_CYC);
        for (int k = 0; k < 5; k++) run_scan(16'h0088, SCAN_CYC);
        for (int k = 0; k < 5; k++) run_scan(16'h0008, SCAN_CYC);
        for (int k = 0; k < 5; k++) run_scan(16'h0000, SCAN_CYC);
        for (int k = 0; k < 8; k++) run_scan((k % 2) ? 16'h0000 : 16'h0080, SCAN_CYC);
        for (int k = 0; k < 6; k++) run_scan(16'h0080, SCAN_CYC);

        for (int n = 0; n < 25; n++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom_range(0, 15);
            b    = (a + $urandom_range(1, 15)) % 16;
            pat  = '0;
            if (kind != 0) pat[a] = 1'b1;
            if (kind == 3) pat[b] = 1'b1;
            hold = $urandom_range(1, 6);
            for (int k = 0; k < hold; k++) run_scan(pat, SCAN_CYC);
        end

        for (int k = 0; k < 5; k++) run_scan(16'h0008, SCAN_CYC);
        run_scan(16'h0008, 2 * SCAN_DIV + 2);
        rst_n = 1'b0;
        #1;
        check_reset_state("midscan reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) run_scan(16'h0008, SCAN_CYC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
